mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and data port.
- Sits between the processor (iadr/imemrd, dadr/dmemrd/dmemwd/dmemread/dmemwrite) and the memory.
- Holds each requester off with a ready handshake, which the pipeline uses as its stall.
- Alternates round-robin when both ports request, and aborts hung accesses with a timeout.

---
 rtl/mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the instruction-fetch port and the data port. Each port is held off until a
// one-cycle ready pulse, contention is resolved round-robin, and an access that
// never sees m_ack is aborted after TIMEOUT cycles and flagged on the sticky err.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   // instruction fetch port
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_ready,
   // data port
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ready,
   // memory side
   output logic                  m_req,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic                  m_ack,
   // status
   output logic                  err
);

   // The counter only has to hold 0..TIMEOUT; it is cleared on every grant.
   localparam int               CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   typedef enum logic {
      PORT_I,
      PORT_D
   } port_t;

   state_t                state_q, state_d;
   port_t                 owner_q, owner_d;
   port_t                 last_grant_q, last_grant_d;
   port_t                 grant;

   logic                  d_req;
   logic                  any_req;
   logic                  timeout_hit;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      cnt_inc;

   logic                  m_req_q, m_req_d;
   logic                  m_we_q, m_we_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
   logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  i_ready_q, i_ready_d;
   logic                  d_ready_q, d_ready_d;
   logic                  err_q, err_d;

   // Request decode, round-robin pick and timeout detection.
   always_comb begin
      d_req   = d_read | d_write;
      any_req = i_req | d_req;
      if (i_req && d_req) begin
         grant = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
      end else if (d_req) begin
         grant = PORT_D;
      end else begin
         grant = PORT_I;
      end
      cnt_inc     = cnt_q + CNT_W'(1);
      // An ack in the final waiting cycle still wins over the abort.
      timeout_hit = !m_ack && (cnt_inc == CNT_LIMIT);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a request starts BUSY, ack or timeout ends it, RESP lasts one cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (m_ack || timeout_hit) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: next values of every registered output and of the bookkeeping flops.
   always_comb begin
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      m_req_d      = m_req_q;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_ready_d    = 1'b0;
      d_ready_d    = 1'b0;
      err_d        = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d      = grant;
               last_grant_d = grant;
               cnt_d        = '0;
               m_req_d      = 1'b1;
               if (grant == PORT_D) begin
                  // read and write together are treated as a write
                  m_addr_d  = d_addr;
                  m_we_d    = d_write;
                  m_wdata_d = d_write ? d_wdata : '0;
               end else begin
                  m_addr_d  = i_addr;
                  m_we_d    = 1'b0;
                  m_wdata_d = '0;
               end
            end
         end
         ST_BUSY: begin
            if (m_ack || timeout_hit) begin
               m_req_d = 1'b0;
               if (owner_q == PORT_I) begin
                  i_ready_d = 1'b1;
                  i_rdata_d = m_ack ? m_rdata : '0;
               end else begin
                  d_ready_d = 1'b1;
                  if (!m_we_q) begin
                     d_rdata_d = m_ack ? m_rdata : '0;
                  end
               end
               if (!m_ack) begin
                  err_d = 1'b1;
                  cnt_d = cnt_inc;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RESP: begin
            // ready pulses fall back to 0 through the defaults
         end
         default: begin
            m_req_d = 1'b0;
         end
      endcase
   end

   // Registered outputs and arbitration bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q      <= PORT_I;
         last_grant_q <= PORT_I;
         cnt_q        <= '0;
         m_req_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         m_req_q      <= m_req_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_ready_q    <= i_ready_d;
         d_ready_q    <= d_ready_d;
         err_q        <= err_d;
      end
   end

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign i_ready = i_ready_q;
   assign d_ready = d_ready_q;
   assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic, checked
// against a transaction-level model of the arbiter (round-robin grant, ready one
// cycle after the ack cycle, abort after TIMEOUT waiting cycles, sticky err).
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ready;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;
   logic          err;

   int checks   = 0;
   int failures = 0;

   // reference model state (0 = I, 1 = D)
   bit            last_g;
   bit            err_m;
   logic [DW-1:0] i_rdata_m;
   logic [DW-1:0] d_rdata_m;

   mem_port_arbiter #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .i_req(i_req),
      .i_addr(i_addr),
      .i_rdata(i_rdata),
      .i_ready(i_ready),
      .d_read(d_read),
      .d_write(d_write),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_rdata(d_rdata),
      .d_ready(d_ready),
      .m_req(m_req),
      .m_we(m_we),
      .m_addr(m_addr),
      .m_wdata(m_wdata),
      .m_rdata(m_rdata),
      .m_ack(m_ack),
      .err(err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Absolute time bound on the whole run.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drop(input bit port_d);
      if (port_d) begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end else begin
         i_req = 1'b0;
      end
   endtask

   task automatic new_d_req();
      int kind;
      kind    = $urandom_range(0, 2);
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_read  = (kind != 1);
      d_write = (kind != 0);
   endtask

   task automatic reset_begin();
      reset   = 1'b1;
      i_req   = 1'b0;
      i_addr  = '0;
      d_read  = 1'b0;
      d_write = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      m_ack   = 1'b0;
      m_rdata = '0;
      last_g    = 1'b0;
      err_m     = 1'b0;
      i_rdata_m = '0;
      d_rdata_m = '0;
      tick();
      tick();
   endtask

   // One transaction, called in an IDLE cycle with requests already driven.
   task automatic txn(input int lat, input logic [DW-1:0] ack_val, input bit withdraw,
                      input bit drop_after, input bit noise);
      bit            gd;
      bit            dreq;
      bit            exp_we;
      bit            timed_out;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wd;
      dreq      = d_read | d_write;
      gd        = (i_req && dreq) ? !last_g : dreq;
      last_g    = gd;
      exp_addr  = gd ? d_addr : i_addr;
      exp_we    = gd && d_write;
      exp_wd    = exp_we ? d_wdata : '0;
      timed_out = (lat > TO);
      m_ack     = 1'b0;
      tick();
      for (int c = 1; c <= TO; c++) begin
         chk("busy_m_req", m_req, 1);
         chk("busy_m_addr", m_addr, exp_addr);
         chk("busy_m_we", m_we, exp_we);
         chk("busy_m_wdata", m_wdata, exp_wd);
         chk("busy_i_ready", i_ready, 0);
         chk("busy_d_ready", d_ready, 0);
         if (withdraw && c == 1) drop(gd);
         if (noise) begin
            if (gd && !i_req && $urandom_range(0, 2) == 0) begin
               i_req  = 1'b1;
               i_addr = $urandom;
            end
            if (!gd && !d_read && !d_write && $urandom_range(0, 2) == 0) new_d_req();
         end
         if (c == lat) begin
            m_ack   = 1'b1;
            m_rdata = ack_val;
            tick();
            m_ack   = 1'b0;
            m_rdata = $urandom;
            break;
         end
         m_rdata = $urandom;
         tick();
      end
      // response cycle
      if (!gd) i_rdata_m = timed_out ? '0 : ack_val;
      else if (!exp_we) d_rdata_m = timed_out ? '0 : ack_val;
      if (timed_out) err_m = 1'b1;
      chk("resp_m_req", m_req, 0);
      chk("resp_i_ready", i_ready, !gd);
      chk("resp_d_ready", d_ready, gd);
      chk("resp_i_rdata", i_rdata, i_rdata_m);
      chk("resp_d_rdata", d_rdata, d_rdata_m);
      chk("resp_err", err, err_m);
      if (drop_after) drop(gd);
      tick();
      chk("idle_i_ready", i_ready, 0);
      chk("idle_d_ready", d_ready, 0);
      chk("idle_m_req", m_req, 0);
   endtask

   // m_ack while the arbiter is idle and nothing is requested.
   task automatic stray_ack();
      m_ack   = 1'b1;
      m_rdata = $urandom;
      tick();
      m_ack   = 1'b0;
      chk("stray_m_req", m_req, 0);
      chk("stray_i_ready", i_ready, 0);
      chk("stray_d_ready", d_ready, 0);
      chk("stray_i_rdata", i_rdata, i_rdata_m);
      chk("stray_d_rdata", d_rdata, d_rdata_m);
      tick();
      chk("stray_m_req2", m_req, 0);
   endtask

   initial begin
      int lat;
      // reset values
      reset_begin();
      chk("rst_m_req", m_req, 0);
      chk("rst_m_we", m_we, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;
      tick();

      // single fetch, ack in first busy cycle
      i_req  = 1'b1;
      i_addr = 32'h40;
      txn(1, 32'h2008_0005, 1'b0, 1'b1, 1'b0);

      // data write, ack after 3 cycles
      d_write = 1'b1;
      d_addr  = 32'h54;
      d_wdata = 32'h7;
      txn(3, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);

      // withdrawn fetch, then stray ack in idle
      i_req  = 1'b1;
      i_addr = 32'h1234;
      txn(2, 32'h5555_AAAA, 1'b1, 1'b1, 1'b0);
      stray_ack();

      // contention from reset: D, I, D, I
      reset_begin();
      i_req  = 1'b1;
      i_addr = 32'h100;
      d_read = 1'b1;
      d_addr = 32'h200;
      reset  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("cont_pick", (d_read && i_req) ? !last_g : 1'b0, (k % 2 == 0) ? 1'b1 : 1'b0);
         txn(1, $urandom, 1'b0, 1'b0, 1'b0);
      end

      // timeout on a data read
      reset_begin();
      reset  = 1'b0;
      d_read = 1'b1;
      d_addr = 32'h88;
      txn(TO + 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
      tick();
      chk("err_sticky", err, 1);

      // reset during BUSY
      i_req  = 1'b1;
      i_addr = 32'h300;
      tick();
      chk("midrst_busy", m_req, 1);
      reset = 1'b1;
      #1;
      chk("midrst_m_req", m_req, 0);
      chk("midrst_i_ready", i_ready, 0);
      chk("midrst_err", err, 0);
      i_req     = 1'b0;
      last_g    = 1'b0;
      err_m     = 1'b0;
      i_rdata_m = '0;
      d_rdata_m = '0;
      tick();
      chk("midrst_i_ready2", i_ready, 0);
      reset = 1'b0;
      tick();
      chk("midrst_after", i_ready, 0);
      i_req  = 1'b1;
      i_addr = 32'h304;
      txn(2, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         if (!i_req && !d_read && !d_write && $urandom_range(0, 3) == 0) stray_ack();
         if (!i_req && $urandom_range(0, 1) == 1) begin
            i_req  = 1'b1;
            i_addr = $urandom;
         end
         if (!d_read && !d_write && $urandom_range(0, 1) == 1) new_d_req();
         if (!i_req && !d_read && !d_write) begin
            i_req  = 1'b1;
            i_addr = $urandom;
         end
         lat = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(1, TO);
         txn(lat, $urandom, $urandom_range(0, 7) == 0, 1'b1, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
